// File: rtl/gps_arb_pkg.sv
// Shared types and constants for the GPS snapshot arbiter.
package gps_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  localparam int REQ_OVERLAY = 0;
  localparam int REQ_LOGGER  = 1;

  localparam int LAT_W = 32;
  localparam int LON_W = 32;
  localparam int SPD_W = 16;

endpackage

// File: rtl/gps_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer remembers the last winner.
module gps_rr_arb2
  import gps_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic last_reg;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant[REQ_OVERLAY] = 1'b1;
      2'b10:   grant[REQ_LOGGER]  = 1'b1;
      2'b11: begin
        // Contention: hand it to whoever did not win last time.
        if (last_reg) grant[REQ_OVERLAY] = 1'b1;
        else          grant[REQ_LOGGER]  = 1'b1;
      end
      default: grant = 2'b00;
    endcase
  end

  // Reset to "logger won last" so the overlay is favoured first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_reg <= 1'b1;
    end else if (en && (grant != 2'b00)) begin
      last_reg <= grant[REQ_LOGGER];
    end
  end

endmodule

// File: rtl/gps_arbiter.sv
// Periodically fetches a GPS fix into a snapshot and hands it to two consumers round-robin.
module gps_arbiter
  import gps_arb_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             gps_req,
  input  logic             gps_ack,
  input  logic [LAT_W-1:0] gps_lat,
  input  logic [LON_W-1:0] gps_lon,
  input  logic [SPD_W-1:0] gps_speed,
  input  logic [1:0]       req,
  output logic [1:0]       gnt,
  output logic [LAT_W-1:0] out_lat,
  output logic [LON_W-1:0] out_lon,
  output logic [SPD_W-1:0] out_speed,
  output logic             out_stale,
  output logic             timeout_err
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state_reg, state_next;
  logic [TICK_W-1:0] tick_reg, tick_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              pending_reg, pending_next;
  logic              gps_req_next, out_stale_next, timeout_err_next;
  logic [1:0]        gnt_next;
  logic [LAT_W-1:0]  out_lat_next;
  logic [LON_W-1:0]  out_lon_next;
  logic [SPD_W-1:0]  out_speed_next;
  logic              wrap, arb_en;
  logic [1:0]        eligible, arb_grant;

  assign wrap      = (tick_reg == TICK_W'(TICK_DIV - 1));
  assign tick_next = wrap ? '0 : tick_reg + 1'b1;
  // A requester just granted is assumed to still be dropping its req.
  assign eligible  = req & ~gnt;
  assign arb_en    = (state_reg == IDLE) && !pending_reg;

  gps_rr_arb2 u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (eligible),
    .en      (arb_en),
    .grant   (arb_grant)
  );

  always_comb begin
    state_next       = state_reg;
    pending_next     = pending_reg | wrap;
    wait_next        = wait_reg;
    gps_req_next     = gps_req;
    gnt_next         = 2'b00;
    timeout_err_next = 1'b0;
    out_lat_next     = out_lat;
    out_lon_next     = out_lon;
    out_speed_next   = out_speed;
    out_stale_next   = out_stale;
    case (state_reg)
      IDLE: begin
        wait_next = '0;
        if (pending_reg) begin
          // Refresh takes priority over any consumer waiting this cycle.
          pending_next = 1'b0;
          state_next   = FETCH;
          gps_req_next = 1'b1;
        end else begin
          gnt_next = arb_grant;
        end
      end
      FETCH: begin
        if (gps_ack) begin
          out_lat_next   = gps_lat;
          out_lon_next   = gps_lon;
          out_speed_next = gps_speed;
          out_stale_next = 1'b0;
          gps_req_next   = 1'b0;
          state_next     = IDLE;
        end else if (wait_reg == WAIT_W'(TIMEOUT - 1)) begin
          out_stale_next   = 1'b1;
          timeout_err_next = 1'b1;
          gps_req_next     = 1'b0;
          state_next       = IDLE;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      tick_reg    <= '0;
      wait_reg    <= '0;
      pending_reg <= 1'b1;
      gps_req     <= 1'b0;
      gnt         <= 2'b00;
      out_lat     <= '0;
      out_lon     <= '0;
      out_speed   <= '0;
      out_stale   <= 1'b1;
      timeout_err <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tick_reg    <= tick_next;
      wait_reg    <= wait_next;
      pending_reg <= pending_next;
      gps_req     <= gps_req_next;
      gnt         <= gnt_next;
      out_lat     <= out_lat_next;
      out_lon     <= out_lon_next;
      out_speed   <= out_speed_next;
      out_stale   <= out_stale_next;
      timeout_err <= timeout_err_next;
    end
  end

endmodule

// File: tb/tb_gps_arbiter.sv
// Directed plus randomized checks of gps_arbiter against a behavioural reference model.
module tb_gps_arbiter;

  localparam int TICK_DIV = 16;
  localparam int TIMEOUT  = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        gps_req;
  logic        gps_ack = 1'b0;
  logic [31:0] gps_lat = '0;
  logic [31:0] gps_lon = '0;
  logic [15:0] gps_speed = '0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  gnt;
  logic [31:0] out_lat;
  logic [31:0] out_lon;
  logic [15:0] out_speed;
  logic        out_stale;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  gps_arbiter #(.TICK_DIV(TICK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .gps_req     (gps_req),
    .gps_ack     (gps_ack),
    .gps_lat     (gps_lat),
    .gps_lon     (gps_lon),
    .gps_speed   (gps_speed),
    .req         (req),
    .gnt         (gnt),
    .out_lat     (out_lat),
    .out_lon     (out_lon),
    .out_speed   (out_speed),
    .out_stale   (out_stale),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: tick phase, refresh flag, fetch age, last winner, expected outputs.
  int        m_tick, m_wait, m_last;
  bit        m_pend, m_fetch, m_stale, m_terr;
  bit [1:0]  m_gnt;
  bit [31:0] m_lat, m_lon;
  bit [15:0] m_spd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tick = 0; m_wait = 0; m_last = 1;
    m_pend = 1'b1; m_fetch = 1'b0; m_stale = 1'b1; m_terr = 1'b0;
    m_gnt = 2'b00; m_lat = '0; m_lon = '0; m_spd = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gps_req"}, 32'(gps_req), 32'(m_fetch));
    chk({tag, ".gnt"}, 32'(gnt), 32'(m_gnt));
    chk({tag, ".lat"}, out_lat, m_lat);
    chk({tag, ".lon"}, out_lon, m_lon);
    chk({tag, ".speed"}, 32'(out_speed), 32'(m_spd));
    chk({tag, ".stale"}, 32'(out_stale), 32'(m_stale));
    chk({tag, ".terr"}, 32'(timeout_err), 32'(m_terr));
  endtask

  // One clock: predict from current inputs, advance, then compare.
  task automatic step(input string tag);
    bit        wrap;
    bit [1:0]  elig;
    int        pick;
    int        n_tick, n_wait, n_last;
    bit        n_pend, n_fetch, n_stale, n_terr;
    bit [1:0]  n_gnt;
    bit [31:0] n_lat, n_lon;
    bit [15:0] n_spd;
    wrap   = (m_tick == TICK_DIV - 1);
    n_tick = (m_tick + 1) % TICK_DIV;
    n_wait = m_wait; n_last = m_last; n_pend = m_pend; n_fetch = m_fetch;
    n_stale = m_stale; n_terr = 1'b0; n_gnt = 2'b00;
    n_lat = m_lat; n_lon = m_lon; n_spd = m_spd;
    if (!m_fetch) begin
      n_wait = 0;
      if (m_pend) begin
        n_pend = 1'b0;
        n_fetch = 1'b1;
      end else begin
        n_pend = wrap;
        elig = req & ~m_gnt;
        pick = -1;
        if (elig == 2'b11) pick = (m_last == 0) ? 1 : 0;
        else if (elig == 2'b01) pick = 0;
        else if (elig == 2'b10) pick = 1;
        if (pick >= 0) begin
          n_gnt = 2'(1 << pick);
          n_last = pick;
        end
      end
    end else begin
      n_pend = m_pend | wrap;
      if (gps_ack) begin
        n_lat = gps_lat; n_lon = gps_lon; n_spd = gps_speed;
        n_stale = 1'b0; n_fetch = 1'b0;
      end else if (m_wait == TIMEOUT - 1) begin
        n_stale = 1'b1; n_terr = 1'b1; n_fetch = 1'b0;
      end else begin
        n_wait = m_wait + 1;
      end
    end
    @(posedge clk);
    #1;
    m_tick = n_tick; m_wait = n_wait; m_last = n_last; m_pend = n_pend;
    m_fetch = n_fetch; m_stale = n_stale; m_terr = n_terr; m_gnt = n_gnt;
    m_lat = n_lat; m_lon = n_lon; m_spd = n_spd;
    check_all(tag);
    if (gnt != 2'b00) $display("t=%0t %s grant=%b lat=%h stale=%b", $time, tag, gnt, out_lat, out_stale);
    if (timeout_err)  $display("t=%0t %s fetch timeout", $time, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.gps_req", 32'(gps_req), 32'd0);
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.stale", 32'(out_stale), 32'd1);
    chk("rst.lat", out_lat, 32'd0);
    chk("rst.terr", 32'(timeout_err), 32'd0);
    reset_n = 1'b1;

    // First fetch acked three cycles after gps_req rises
    step("fetch1");
    chk("fetch1.req_up", 32'(gps_req), 32'd1);
    step("fetch1");
    step("fetch1");
    gps_ack = 1'b1; gps_lat = 32'h12345678; gps_lon = 32'h87654321; gps_speed = 16'd60;
    step("fetch1");
    gps_ack = 1'b0; gps_lat = '0; gps_lon = '0; gps_speed = '0;
    chk("fetch1.lat", out_lat, 32'h12345678);
    chk("fetch1.lon", out_lon, 32'h87654321);
    chk("fetch1.speed", 32'(out_speed), 32'd60);
    chk("fetch1.stale", 32'(out_stale), 32'd0);
    chk("fetch1.req_down", 32'(gps_req), 32'd0);

    // Both consumers requesting: alternate starting with overlay
    req = 2'b11;
    step("rr"); chk("rr.g0", 32'(gnt), 32'h1);
    step("rr"); chk("rr.g1", 32'(gnt), 32'h2);
    step("rr"); chk("rr.g2", 32'(gnt), 32'h1);
    chk("rr.data", out_lat, 32'h12345678);
    req = 2'b00;
    step("rr_idle");

    // Timeout: no ack for TIMEOUT cycles
    for (int i = 0; i < 40 && !gps_req; i++) step("wait_tick");
    chk("to.req_up", 32'(gps_req), 32'd1);
    for (int i = 0; i < TIMEOUT - 1; i++) step("to");
    chk("to.no_err_yet", 32'(timeout_err), 32'd0);
    step("to");
    chk("to.err", 32'(timeout_err), 32'd1);
    chk("to.stale", 32'(out_stale), 32'd1);
    chk("to.lat_kept", out_lat, 32'h12345678);
    step("to_after");
    chk("to.pulse", 32'(timeout_err), 32'd0);

    // Next fetch at the next wrap; ack on the last allowed cycle
    for (int i = 0; i < 40 && !gps_req; i++) step("wait_tick");
    chk("late.req_up", 32'(gps_req), 32'd1);
    for (int i = 0; i < TIMEOUT - 1; i++) step("late");
    gps_ack = 1'b1; gps_lat = 32'hA5A5_0001; gps_lon = 32'h5A5A_0002; gps_speed = 16'd123;
    step("late");
    chk("late.no_err", 32'(timeout_err), 32'd0);
    chk("late.lat", out_lat, 32'hA5A5_0001);
    chk("late.stale", 32'(out_stale), 32'd0);
    // Stray ack while idle
    gps_lat = 32'hDEAD_BEEF; gps_lon = 32'hFEED_F00D; gps_speed = 16'd999;
    step("stray");
    gps_ack = 1'b0;
    chk("stray.lat", out_lat, 32'hA5A5_0001);
    chk("stray.speed", 32'(out_speed), 32'd123);

    // Request arriving together with a pending refresh: fetch first, grant after
    for (int i = 0; i < 40 && !(m_pend && !m_fetch); i++) step("wait_wrap");
    req = 2'b01;
    step("prio");
    chk("prio.fetch", 32'(gps_req), 32'd1);
    chk("prio.no_gnt", 32'(gnt), 32'd0);
    step("prio");
    gps_ack = 1'b1; gps_lat = 32'h0000_1111; gps_lon = 32'h0000_2222; gps_speed = 16'd7;
    step("prio");
    gps_ack = 1'b0;
    chk("prio.withheld", 32'(gnt), 32'd0);
    step("prio");
    chk("prio.gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    step("prio_done");

    // Asynchronous reset in the middle of a fetch
    for (int i = 0; i < 40 && !gps_req; i++) step("wait_tick");
    step("mid");
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst.gps_req", 32'(gps_req), 32'd0);
    chk("arst.stale", 32'(out_stale), 32'd1);
    chk("arst.lat", out_lat, 32'd0);
    chk("arst.speed", 32'(out_speed), 32'd0);
    chk("arst.gnt", 32'(gnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    step("rel");
    chk("rel.refetch", 32'(gps_req), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      req       = 2'($urandom_range(0, 3));
      gps_ack   = ($urandom_range(0, 4) == 0);
      gps_lat   = $urandom;
      gps_lon   = $urandom;
      gps_speed = 16'($urandom);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
